i2c_config_sequencer: RTL and testbench

Upstream companion of the I2C write controller. Walks a table of 24-bit register-write words (slave address, register, data) after power-up and hands each word to the controller. Each handoff is a GO/END/ACK handshake. The block also generates the divided clock that the controller runs on, and retries or flags transfers the slave did not acknowledge. It sits between board reset and the controller, and configures an external device such as an HDMI transmitter or codec.

---
 rtl/i2c_cfg_pkg.sv | 30 +++
 rtl/i2c_config_rom.sv | 62 ++++++
 rtl/i2c_config_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_i2c_config_sequencer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_cfg_pkg.sv
// ---------------------------------------------------------------------------
// i2c_cfg_pkg
// Shared definitions for the I2C configuration sequencer:
//   - cfg_state_t : sequencer FSM states
//   - I2C_WORD_W  : width of one table word {slave addr, reg, data}
//   - div_ratio() : CLOCK cycles per half period of the controller clock
// ---------------------------------------------------------------------------
package i2c_cfg_pkg;

    localparam int I2C_WORD_W = 24;

    typedef enum logic [2:0] {
        ST_POWERUP,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_END,
        ST_CHECK,
        ST_DONE
    } cfg_state_t;

    // Half-period divide ratio; never below 1 so the divider always runs.
    function automatic int div_ratio(input int clk_freq, input int ctrl_freq);
        int d;
        d = clk_freq / (2 * ctrl_freq);
        if (d < 1) d = 1;
        return d;
    endfunction

endpackage

// File: rtl/i2c_config_rom.sv
// ---------------------------------------------------------------------------
// i2c_config_rom
// Combinational register-write table for the board's I2C slave (here an
// HDMI transmitter at write address 0x72). Each word is {addr, reg, data}.
// Ports:
//   index : table entry to read
//   word  : 24-bit register-write word; 0 for index >= LUT_SIZE
// ---------------------------------------------------------------------------
module i2c_config_rom
    import i2c_cfg_pkg::*;
#(
    parameter int LUT_SIZE = 31,
    parameter int IDX_W    = $clog2(LUT_SIZE + 1)
) (
    input  logic [IDX_W-1:0]      index,
    output logic [I2C_WORD_W-1:0] word
);

    int idx_i;

    always_comb begin
        word  = '0;
        idx_i = int'(index);
        if (idx_i < LUT_SIZE) begin
            case (idx_i)
                0:  word = 24'h72_41_10;
                1:  word = 24'h72_98_03;
                2:  word = 24'h72_9A_E0;
                3:  word = 24'h72_9C_30;
                4:  word = 24'h72_9D_61;
                5:  word = 24'h72_A2_A4;
                6:  word = 24'h72_A3_A4;
                7:  word = 24'h72_E0_D0;
                8:  word = 24'h72_F9_00;
                9:  word = 24'h72_15_00;
                10: word = 24'h72_16_30;
                11: word = 24'h72_17_02;
                12: word = 24'h72_18_46;
                13: word = 24'h72_AF_06;
                14: word = 24'h72_40_80;
                15: word = 24'h72_4C_04;
                16: word = 24'h72_D6_C0;
                17: word = 24'h72_55_10;
                18: word = 24'h72_56_08;
                19: word = 24'h72_96_F6;
                20: word = 24'h72_73_07;
                21: word = 24'h72_76_1F;
                22: word = 24'h72_3B_80;
                23: word = 24'h72_BA_60;
                24: word = 24'h72_D0_3C;
                25: word = 24'h72_94_C0;
                26: word = 24'h72_E4_60;
                27: word = 24'h72_FA_7D;
                28: word = 24'h72_3C_10;
                29: word = 24'h72_01_00;
                30: word = 24'h72_0A_41;
                default: word = '0;
            endcase
        end
    end

endmodule

// File: rtl/i2c_config_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_config_sequencer
// Walks the register-write table after power-up and hands each word to the
// I2C write controller with a GO/END/ACK handshake. Also generates the
// controller clock and retries or flags transfers the slave did not ACK.
// Optional feature macro: I2C_CFG_RETRY_EN (retry up to MAX_RETRY extra
// attempts per entry; when undefined, any failure just sets CFG_ERROR).
// Ports:
//   CLOCK, RESET_N  : system clock, asynchronous active-low reset
//   REINIT          : single-cycle pulse, restart the table from entry 0
//   I2C_CTRL_CLK    : 50% duty divided clock for the controller
//   I2C_GO, I2C_DATA: transfer request and {addr, reg, data} word
//   I2C_END, I2C_ACK: controller end flag (low while busy) and NACK flag
//   CFG_INDEX       : current table entry
//   CFG_DONE        : all entries processed
//   CFG_ERROR       : sticky, some entry failed after all attempts
// ---------------------------------------------------------------------------
module i2c_config_sequencer
    import i2c_cfg_pkg::*;
#(
    parameter int  CLK_FREQ      = 50_000_000,
    parameter int  I2C_CTRL_FREQ = 20_000,
    parameter int  LUT_SIZE      = 31,
    parameter int  POWERUP_TICKS = 1000,
    parameter int  BUSY_TIMEOUT  = 256,
    parameter int  MAX_RETRY     = 3,
    localparam int IDX_W         = $clog2(LUT_SIZE + 1)
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  REINIT,
    output logic                  I2C_CTRL_CLK,
    output logic                  I2C_GO,
    output logic [I2C_WORD_W-1:0] I2C_DATA,
    input  logic                  I2C_END,
    input  logic                  I2C_ACK,
    output logic [IDX_W-1:0]      CFG_INDEX,
    output logic                  CFG_DONE,
    output logic                  CFG_ERROR
);

    localparam int DIV   = div_ratio(CLK_FREQ, I2C_CTRL_FREQ);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    localparam int PU_TICKS = (POWERUP_TICKS < 1) ? 1 : POWERUP_TICKS;
    localparam int PU_W     = $clog2(PU_TICKS + 1);
    localparam logic [PU_W-1:0] PU_LAST = PU_W'(PU_TICKS - 1);

    localparam int BT_TICKS = (BUSY_TIMEOUT < 1) ? 1 : BUSY_TIMEOUT;
    localparam int TO_W     = $clog2(BT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(BT_TICKS - 1);

    localparam logic [IDX_W-1:0] IDX_END = IDX_W'(LUT_SIZE);

    cfg_state_t            state;
    logic [DIV_W-1:0]      div_cnt;
    logic [PU_W-1:0]       pu_cnt;
    logic [TO_W-1:0]       to_cnt;
    logic                  timed_out;
    logic                  reinit_q;
    logic                  reinit_pend;
    logic                  reinit_take;
    logic                  tick;
    logic                  xfer_fail;
    logic                  retry_left;
    logic [I2C_WORD_W-1:0] rom_word;

    i2c_config_rom #(
        .LUT_SIZE (LUT_SIZE),
        .IDX_W    (IDX_W)
    ) u_rom (
        .index (CFG_INDEX),
        .word  (rom_word)
    );

`ifdef I2C_CFG_RETRY_EN
    localparam int RT_MAX = (MAX_RETRY < 0) ? 0 : MAX_RETRY;
    localparam int RT_W   = (RT_MAX > 0) ? $clog2(RT_MAX + 1) : 1;
    localparam logic [RT_W-1:0] RT_LIMIT = RT_W'(RT_MAX);

    logic [RT_W-1:0] retry_cnt;
    assign retry_left = (retry_cnt < RT_LIMIT);
`else
    // Without the retry counter the attempt limit has no effect.
    logic unused_max_retry;
    assign unused_max_retry = ^MAX_RETRY;
    assign retry_left       = 1'b0;
`endif

    // tick marks the CLOCK cycle whose edge raises I2C_CTRL_CLK.
    assign tick = (div_cnt == DIV_LAST) && !I2C_CTRL_CLK;

    // A REINIT pulse may arrive at any time; it is only honoured between
    // transfers so a started transfer always runs to completion.
    assign reinit_pend = reinit_q | REINIT;
    assign reinit_take = tick && reinit_pend && ((state == ST_LOAD) || (state == ST_DONE));

    // A busy timeout counts as a failure regardless of the stale ACK flag.
    assign xfer_fail = timed_out | I2C_ACK;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_cnt      <= '0;
            I2C_CTRL_CLK <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt      <= '0;
            I2C_CTRL_CLK <= ~I2C_CTRL_CLK;
        end else begin
            div_cnt      <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= ST_POWERUP;
            pu_cnt    <= '0;
            to_cnt    <= '0;
            timed_out <= 1'b0;
            reinit_q  <= 1'b0;
            I2C_GO    <= 1'b0;
            I2C_DATA  <= '0;
            CFG_INDEX <= '0;
            CFG_DONE  <= 1'b0;
            CFG_ERROR <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
            retry_cnt <= '0;
`endif
        end else begin
            reinit_q <= reinit_take ? 1'b0 : reinit_pend;
            if (reinit_take) begin
                I2C_GO    <= 1'b0;
                CFG_INDEX <= '0;
                CFG_DONE  <= 1'b0;
                CFG_ERROR <= 1'b0;
`ifdef I2C_CFG_RETRY_EN
                retry_cnt <= '0;
`endif
                state     <= ST_LOAD;
            end else if (tick) begin
                case (state)
                    ST_POWERUP: begin
                        if (pu_cnt == PU_LAST) begin
                            pu_cnt <= '0;
                            state  <= ST_LOAD;
                        end else begin
                            pu_cnt <= pu_cnt + 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        if (CFG_INDEX == IDX_END) begin
                            CFG_DONE <= 1'b1;
                            state    <= ST_DONE;
                        end else begin
                            I2C_DATA <= rom_word;
                            state    <= ST_START;
                        end
                    end
                    ST_START: begin
                        I2C_GO    <= 1'b1;
                        to_cnt    <= '0;
                        timed_out <= 1'b0;
                        state     <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        if (!I2C_END) begin
                            state <= ST_WAIT_END;
                        end else if (to_cnt == TO_LAST) begin
                            timed_out <= 1'b1;
                            state     <= ST_CHECK;
                        end else begin
                            to_cnt <= to_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_END: begin
                        if (I2C_END) state <= ST_CHECK;
                    end
                    ST_CHECK: begin
                        // GO low for this tick gives the controller a fresh
                        // rising edge if the entry is retried.
                        I2C_GO <= 1'b0;
                        if (xfer_fail && retry_left) begin
`ifdef I2C_CFG_RETRY_EN
                            retry_cnt <= retry_cnt + 1'b1;
`endif
                            state <= ST_START;
                        end else begin
                            if (xfer_fail) CFG_ERROR <= 1'b1;
`ifdef I2C_CFG_RETRY_EN
                            retry_cnt <= '0;
`endif
                            CFG_INDEX <= CFG_INDEX + 1'b1;
                            state     <= ST_LOAD;
                        end
                    end
                    ST_DONE: begin
                        I2C_GO   <= 1'b0;
                        CFG_DONE <= 1'b1;
                    end
                    default: state <= ST_POWERUP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_config_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_config_sequencer
// Directed bench for i2c_config_sequencer with a behavioural write
// controller. Expectations adapt to whether I2C_CFG_RETRY_EN is defined.
// ---------------------------------------------------------------------------
module tb_i2c_config_sequencer;

`ifdef I2C_CFG_RETRY_EN
    localparam bit RETRY_ON = 1'b1;
`else
    localparam bit RETRY_ON = 1'b0;
`endif

    localparam logic [23:0] ROM0 = 24'h72_41_10;
    localparam logic [23:0] ROM1 = 24'h72_98_03;
    localparam logic [23:0] ROM2 = 24'h72_9A_E0;

    logic        CLOCK;
    logic        RESET_N;
    logic        REINIT;
    logic        I2C_CTRL_CLK;
    logic        I2C_GO;
    logic [23:0] I2C_DATA;
    logic        ctl_end;
    logic        ctl_ack;
    logic [1:0]  CFG_INDEX;
    logic        CFG_DONE;
    logic        CFG_ERROR;

    int n_cmp = 0;
    int n_mis = 0;

    // Controller model state
    int          mode = 0;   // 0 ack all, 1 nack entry1 twice, 2 nack entry1 always, 3 hang on entry1
    int          base = 0;   // first log slot of the current test
    logic [23:0] xfer_log[$];
    logic        go_q;
    int          busy;
    int          prior;
    logic        is1;

    i2c_config_sequencer #(
        .CLK_FREQ      (8),
        .I2C_CTRL_FREQ (1),
        .LUT_SIZE      (3),
        .POWERUP_TICKS (2),
        .BUSY_TIMEOUT  (256),
        .MAX_RETRY     (3)
    ) dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .REINIT       (REINIT),
        .I2C_CTRL_CLK (I2C_CTRL_CLK),
        .I2C_GO       (I2C_GO),
        .I2C_DATA     (I2C_DATA),
        .I2C_END      (ctl_end),
        .I2C_ACK      (ctl_ack),
        .CFG_INDEX    (CFG_INDEX),
        .CFG_DONE     (CFG_DONE),
        .CFG_ERROR    (CFG_ERROR)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    function automatic int count_word(input int from, input logic [23:0] w);
        int c = 0;
        for (int i = from; i < xfer_log.size(); i++)
            if (xfer_log[i] == w) c++;
        return c;
    endfunction

    // Behavioural controller: a GO rising edge starts a 3-tick transfer.
    always @(posedge I2C_CTRL_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctl_end = 1'b1;
            ctl_ack = 1'b0;
            go_q    = 1'b0;
            busy    = 0;
        end else begin
            #1;
            if (busy > 0) begin
                busy = busy - 1;
                if (busy == 0) ctl_end = 1'b1;
            end else if (I2C_GO && !go_q) begin
                prior = count_word(base, ROM1);
                is1   = (I2C_DATA == ROM1);
                xfer_log.push_back(I2C_DATA);
                if (mode == 3 && is1) begin
                    ctl_ack = 1'b0;
                end else begin
                    ctl_end = 1'b0;
                    busy    = 3;
                    ctl_ack = (mode == 1 && is1 && prior < 2) || (mode == 2 && is1);
                end
            end
            go_q = I2C_GO;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_mis++;
            $display("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!CFG_DONE && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        chk(tag, 32'(CFG_DONE), 1);
    endtask

    task automatic wait_log(input string tag, input int cnt, input int budget);
        int n = 0;
        while ((xfer_log.size() - base) < cnt && n < budget) begin
            @(negedge CLOCK);
            n++;
        end
        chk(tag, xfer_log.size() - base, cnt);
    endtask

    initial begin
        int          go_k;
        int          n;
        logic [23:0] go_data;
        logic [1:0]  go_idx;
        logic [23:0] seq [5];

        RESET_N = 1'b0;
        REINIT  = 1'b0;
        go_data = '0;
        go_idx  = '0;

        // ---- reset, divider, clean run ----
        repeat (3) @(negedge CLOCK);
        chk("rst_outs", 32'({I2C_CTRL_CLK, I2C_GO, CFG_DONE, CFG_ERROR, CFG_INDEX, I2C_DATA}), 0);
        RESET_N = 1'b1;
        go_k = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
            if (k <= 16) chk("div_clk", 32'(I2C_CTRL_CLK), (k / 4) % 2);
            if (I2C_GO && go_k == 0) begin
                go_k    = k;
                go_data = I2C_DATA;
                go_idx  = CFG_INDEX;
            end
        end
        chk("go_rise_cycle", go_k, 28);
        chk("go_data", 32'(go_data), 32'(ROM0));
        chk("go_index", 32'(go_idx), 0);
        wait_done("clean_done", 2000);
        chk("clean_err", 32'(CFG_ERROR), 0);
        chk("clean_index", 32'(CFG_INDEX), 3);
        chk("clean_go_low", 32'(I2C_GO), 0);
        chk("clean_count", xfer_log.size() - base, 3);
        chk("clean_w0", 32'(xfer_log[base]), 32'(ROM0));
        chk("clean_w1", 32'(xfer_log[base + 1]), 32'(ROM1));
        chk("clean_w2", 32'(xfer_log[base + 2]), 32'(ROM2));

        // ---- NACK twice on entry 1, then ACK ----
        mode = 1;
        base = xfer_log.size();
        do_reset();
        wait_done("nack2_done", 3000);
        chk("nack2_tries", count_word(base, ROM1), RETRY_ON ? 3 : 1);
        chk("nack2_err", 32'(CFG_ERROR), RETRY_ON ? 0 : 1);
        chk("nack2_total", xfer_log.size() - base, RETRY_ON ? 5 : 3);
        chk("nack2_last", 32'(xfer_log[xfer_log.size() - 1]), 32'(ROM2));

        // ---- entry 1 always NACKed ----
        mode = 2;
        base = xfer_log.size();
        do_reset();
        wait_done("nackall_done", 3000);
        chk("nackall_tries", count_word(base, ROM1), RETRY_ON ? 4 : 1);
        chk("nackall_err", 32'(CFG_ERROR), 1);
        chk("nackall_index", 32'(CFG_INDEX), 3);
        chk("nackall_last", 32'(xfer_log[xfer_log.size() - 1]), 32'(ROM2));

        // ---- REINIT in DONE: fast restart, error cleared ----
        mode = 0;
        base = xfer_log.size();
        REINIT = 1'b1;
        @(negedge CLOCK);
        REINIT = 1'b0;
        n = 1;
        while (!I2C_GO && n < 60) begin
            @(negedge CLOCK);
            n++;
        end
        chk("reinit_fast", 32'(n >= 17 && n <= 24), 1);
        chk("reinit_done_clr", 32'(CFG_DONE), 0);
        chk("reinit_err_clr", 32'(CFG_ERROR), 0);
        chk("reinit_idx", 32'(CFG_INDEX), 0);
        chk("reinit_data", 32'(I2C_DATA), 32'(ROM0));
        wait_done("reinit_done", 2000);
        chk("reinit_total", xfer_log.size() - base, 3);
        chk("reinit_err_end", 32'(CFG_ERROR), 0);

        // ---- busy timeout on entry 1 ----
        mode = 3;
        base = xfer_log.size();
        do_reset();
        n = 0;
        while (!(I2C_GO && CFG_INDEX == 2'd1) && n < 3000) begin
            @(negedge CLOCK);
            n++;
        end
        chk("to_start_idx", 32'(CFG_INDEX), 1);
        n = 0;
        while (I2C_GO && n < 3000) begin
            @(negedge CLOCK);
            n++;
        end
        chk("to_go_len", n, 257 * 8);
        wait_done("to_done", 15000);
        chk("to_err", 32'(CFG_ERROR), 1);
        chk("to_tries", count_word(base, ROM1), RETRY_ON ? 4 : 1);
        chk("to_last", 32'(xfer_log[xfer_log.size() - 1]), 32'(ROM2));

        // ---- REINIT during entry 1 transfer ----
        mode = 0;
        base = xfer_log.size();
        do_reset();
        wait_log("mid_seen1", 2, 1000);
        repeat (12) @(negedge CLOCK);
        chk("mid_idx", 32'(CFG_INDEX), 1);
        chk("mid_busy", 32'(ctl_end), 0);
        REINIT = 1'b1;
        @(negedge CLOCK);
        REINIT = 1'b0;
        wait_log("mid_restart", 3, 1000);
        chk("mid_restart_idx", 32'(CFG_INDEX), 0);
        wait_done("mid_done", 3000);
        seq[0] = ROM0; seq[1] = ROM1; seq[2] = ROM0; seq[3] = ROM1; seq[4] = ROM2;
        chk("mid_total", xfer_log.size() - base, 5);
        for (int i = 0; i < 5; i++)
            chk("mid_seq", 32'(xfer_log[base + i]), 32'(seq[i]));
        chk("mid_err", 32'(CFG_ERROR), 0);
        chk("mid_index", 32'(CFG_INDEX), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
